// File: rtl/square_iter.sv
// Iterative fixed-point squarer: ufix15_En11 operand in, ufix15_En8 square out.
// One shift-add partial product per cycle, then a round-to-nearest/saturate step.
module square_iter #(
    parameter int IN_W     = 15,
    parameter int IN_FRAC  = 11,
    parameter int OUT_W    = 15,
    parameter int OUT_FRAC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ovf
);

    localparam int ACC_W = 2 * IN_W;
    localparam int SH    = 2 * IN_FRAC - OUT_FRAC;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    // Half an output LSB expressed in accumulator units; ties round up.
    localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ROUND,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [IN_W-1:0]  r_mcand;
    logic [IN_W-1:0]  r_mplier;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_out_ovf;
    logic [OUT_W-1:0] r_out_data;

    logic             w_accept;
    logic             w_out_fire;
    logic             w_last;
    logic [ACC_W-1:0] w_addend;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W:0]   w_r;
    logic             w_sat;

    assign w_accept   = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_last     = (r_count == CNT_W'(IN_W - 1));
    assign w_addend   = {{IN_W{1'b0}}, r_mcand} << r_count;

    // One extra bit keeps the rounding carry before the saturation test.
    assign w_sum = {1'b0, r_acc} + HALF;
    assign w_r   = w_sum >> SH;
    assign w_sat = |w_r[ACC_W:OUT_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default before any branch, so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_next = S_CALC;
            S_CALC:  if (w_last)     w_state_next = S_ROUND;
            S_ROUND:                 w_state_next = S_DONE;
            S_DONE:  if (w_out_fire) w_state_next = S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_data  <= '0;
        end else begin
            // Registered from the next state so in_ready never sees out_ready combinationally.
            r_in_ready <= (w_state_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= in_data;
                        r_mplier <= in_data;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                S_CALC: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_W'(1);
                end
                S_ROUND: begin
                    r_out_data  <= w_sat ? {OUT_W{1'b1}} : w_r[OUT_W-1:0];
                    r_out_ovf   <= w_sat;
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule
